// File: rtl/kbd_event_ctrl_if.sv
// Bus between the keyboard-event controller and its surroundings: adapter
// key level inputs, CPU read/clear strobes and the FIFO status/data outputs.
interface kbd_event_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [6:0]    key_data;
  logic          key_status;
  logic          rd_en;
  logic          clr_ovf;
  logic [6:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output key_data, key_status, rd_en, clr_ovf,
    input  rd_data, empty, full, count, overflow
  );

  modport slave (
    input  key_data, key_status, rd_en, clr_ovf,
    output rd_data, empty, full, count, overflow
  );
endinterface

// File: rtl/kbd_event_ctrl.sv
// Key-event scheduler: turns level-style key inputs into press events with
// typematic auto-repeat, queues them in a show-ahead FIFO drained by the CPU,
// and flags dropped events with a sticky overflow bit.
module kbd_event_ctrl #(
  parameter int DEPTH        = 8,
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_RATE  = 100000
) (
  input logic             clk,
  input logic             rst,
  kbd_event_ctrl_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DLY_LD  = RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RATE_LD = RW'((REPEAT_RATE  > 0) ? REPEAT_RATE  - 1 : 0);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [6:0]    cur_data, prv_data;
  logic          cur_stat, prv_stat;
  logic          press_ev;

  state_t        state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          push;

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          do_pop, do_push, drop;

  // Register the adapter outputs and keep the previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_data <= '0;
      cur_stat <= 1'b0;
      prv_data <= '0;
      prv_stat <= 1'b0;
    end else begin
      prv_data <= cur_data;
      prv_stat <= cur_stat;
      cur_data <= bus.key_data;
      cur_stat <= bus.key_status;
    end
  end

  // New press or rollover to a different mapped key.
  assign press_ev = cur_stat && (cur_data != '0) && (!prv_stat || (cur_data != prv_data));

  // Repeat FSM state and delay/rate counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Next state: release beats everything, a press restarts the delay timer.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (!cur_stat) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else if (press_ev) begin
      if (REPEAT_DELAY > 0) begin
        state_d = DELAY;
        rcnt_d  = DLY_LD;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        DELAY, REPEAT: begin
          if (rcnt_q == '0) begin
            state_d = REPEAT;
            rcnt_d  = RATE_LD;
          end else begin
            rcnt_d = rcnt_q - RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Push request: every press, plus each expiry of the repeat timer while held.
  always_comb begin
    push = 1'b0;
    if (press_ev)
      push = 1'b1;
    else if (cur_stat && (state_q != IDLE) && (rcnt_q == '0))
      push = 1'b1;
  end

  // A same-cycle pop frees a slot, so a push into a full FIFO is still taken.
  assign do_pop  = bus.rd_en && (cnt != '0);
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);
  assign drop    = push && !do_push;

  // FIFO pointers, occupancy and sticky overflow (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
      if (drop)
        ovf <= 1'b1;
      else if (bus.clr_ovf)
        ovf <= 1'b0;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= cur_data;
  end

  assign bus.empty    = (cnt == '0);
  assign bus.full     = (cnt == CW'(DEPTH));
  assign bus.count    = cnt;
  assign bus.overflow = ovf;
  assign bus.rd_data  = (cnt == '0) ? 7'h00 : mem[rptr];
endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Randomized bench for kbd_event_ctrl: two instances (with and without
// auto-repeat) share one stimulus stream and are compared every cycle against
// a timeline-based reference model.
module tb_kbd_event_ctrl;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] key_data;
  logic       key_status;
  logic       rd_en;
  logic       clr_ovf;

  always #5 clk = ~clk;

  kbd_event_ctrl_if #(.DEPTH(DEPTH)) bus0 ();
  kbd_event_ctrl_if #(.DEPTH(DEPTH)) bus1 ();

  assign bus0.key_data   = key_data;
  assign bus0.key_status = key_status;
  assign bus0.rd_en      = rd_en;
  assign bus0.clr_ovf    = clr_ovf;
  assign bus1.key_data   = key_data;
  assign bus1.key_status = key_status;
  assign bus1.rd_en      = rd_en;
  assign bus1.clr_ovf    = clr_ovf;

  kbd_event_ctrl #(.DEPTH(DEPTH), .REPEAT_DELAY(10), .REPEAT_RATE(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  kbd_event_ctrl #(.DEPTH(DEPTH), .REPEAT_DELAY(0), .REPEAT_RATE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per instance, an ordered list of queued codes and the
  // cycle of the last press; repeats fall at press+DELAY+k*RATE.
  int         dly [2]  = '{10, 0};
  int         rate [2] = '{4, 1};
  logic [6:0] mf [2][DEPTH];
  int         msz [2];
  bit         movf [2];
  int         press_t [2];
  bit         active [2];
  logic [6:0] m_cur_d, m_prv_d;
  bit         m_cur_s, m_prv_s;
  int         t = 0;

  int rd_pct  = 0;
  int clr_pct = 0;
  int pcts [4] = '{0, 10, 30, 60};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic model_edge();
    bit pev, push, pop, dropped;
    int el;
    t++;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        msz[i] = 0; movf[i] = 1'b0; active[i] = 1'b0; press_t[i] = 0;
      end
      m_cur_d = '0; m_prv_d = '0; m_cur_s = 1'b0; m_prv_s = 1'b0;
    end else begin
      pev = m_cur_s && (m_cur_d != 7'h00) && (!m_prv_s || (m_cur_d != m_prv_d));
      for (int i = 0; i < 2; i++) begin
        push = 1'b0;
        if (!m_cur_s) begin
          active[i] = 1'b0;
        end else if (pev) begin
          push = 1'b1;
          press_t[i] = t;
          active[i] = (dly[i] > 0);
        end else if (active[i]) begin
          el = t - press_t[i];
          if (el >= dly[i] && ((el - dly[i]) % rate[i]) == 0) push = 1'b1;
        end
        pop = rd_en && (msz[i] > 0);
        if (pop) begin
          for (int j = 0; j < DEPTH - 1; j++) mf[i][j] = mf[i][j+1];
          msz[i]--;
        end
        dropped = 1'b0;
        if (push) begin
          if (msz[i] < DEPTH) begin
            mf[i][msz[i]] = m_cur_d;
            msz[i]++;
          end else begin
            dropped = 1'b1;
          end
        end
        if (dropped) movf[i] = 1'b1;
        else if (clr_ovf) movf[i] = 1'b0;
      end
      m_prv_d = m_cur_d; m_prv_s = m_cur_s;
      m_cur_d = key_data; m_cur_s = key_status;
    end
  endtask

  task automatic compare();
    check("d0.rd_data",  int'(bus0.rd_data),  (msz[0] > 0) ? int'(mf[0][0]) : 0);
    check("d0.empty",    int'(bus0.empty),    int'(msz[0] == 0));
    check("d0.full",     int'(bus0.full),     int'(msz[0] == DEPTH));
    check("d0.count",    int'(bus0.count),    msz[0]);
    check("d0.overflow", int'(bus0.overflow), int'(movf[0]));
    check("d1.rd_data",  int'(bus1.rd_data),  (msz[1] > 0) ? int'(mf[1][0]) : 0);
    check("d1.empty",    int'(bus1.empty),    int'(msz[1] == 0));
    check("d1.full",     int'(bus1.full),     int'(msz[1] == DEPTH));
    check("d1.count",    int'(bus1.count),    msz[1]);
    check("d1.overflow", int'(bus1.overflow), int'(movf[1]));
  endtask

  // One clock: randomize strobes, let the DUT and model take the edge, then compare.
  task automatic cyc(input int n);
    repeat (n) begin
      rd_en   = ($urandom_range(99, 0) < rd_pct);
      clr_ovf = ($urandom_range(99, 0) < clr_pct);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
    end
  endtask

  function automatic logic [6:0] rand_code();
    if ($urandom_range(9, 0) == 0) return 7'h00;
    return 7'($urandom_range(127, 1));
  endfunction

  initial begin
    rst = 1'b1; key_data = '0; key_status = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    // Single press held 20 cycles, then drain.
    key_data = 7'h41; key_status = 1'b1;
    cyc(20);
    key_status = 1'b0;
    cyc(5);
    rd_pct = 100;
    cyc(10);
    rd_pct = 0;

    // Rollover to another key, then to an unmapped code.
    key_data = 7'h61; key_status = 1'b1;
    cyc(6);
    key_data = 7'h62;
    cyc(16);
    key_data = 7'h00;
    cyc(3);
    key_status = 1'b0;
    cyc(3);
    rd_pct = 100;
    cyc(12);
    rd_pct = 0;

    // Nine short presses without reads overflow the FIFO; then clear and drain.
    for (int k = 0; k < 9; k++) begin
      key_data = 7'(8'h30 + k); key_status = 1'b1;
      cyc(3);
      key_status = 1'b0;
      cyc(1);
    end
    clr_pct = 100;
    cyc(1);
    clr_pct = 0;
    rd_pct = 100;
    cyc(10);
    rd_pct = 0;

    // Randomized segments: holds, rollovers, read pressure, clears, resets.
    for (int s = 0; s < 90; s++) begin
      int hold;
      int roll_at;
      int rst_at;
      bit do_rst;
      hold    = $urandom_range(40, 1);
      roll_at = ($urandom_range(2, 0) == 0) ? $urandom_range(hold - 1, 0) : -1;
      do_rst  = ($urandom_range(9, 0) == 0);
      rst_at  = $urandom_range(hold - 1, 0);
      rd_pct  = pcts[$urandom_range(3, 0)];
      clr_pct = 3;
      key_data = rand_code(); key_status = 1'b1;
      for (int c = 0; c < hold; c++) begin
        if (c == roll_at) key_data = rand_code();
        rst = do_rst && (c == rst_at);
        cyc(1);
      end
      rst = 1'b0;
      if ($urandom_range(3, 0) != 0) begin
        key_status = 1'b0;
        key_data = 7'($urandom_range(127, 0));
        cyc($urandom_range(5, 1));
      end
    end

    key_status = 1'b0;
    rd_pct = 100;
    cyc(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
